// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_pkg: shared read-FSM type, pointer-width helper and almost-flag threshold
package ram_fifo_pkg;
    typedef enum logic {IDLE, ACTIVE} rd_state_e;
    localparam int ALMOST_THR = 2;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: upstream/downstream handshakes and RAM port bundle
interface ram_fifo_ctrl_if #(parameter int WIDTH = 8, parameter int DEPTH = 16);
    localparam int AW = $clog2(DEPTH);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             ram_wr_en;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    modport master (
        output s_valid, s_data, m_ready, ram_rdata,
        input  s_ready, m_valid, m_data, ram_wr_en, ram_waddr, ram_wdata, ram_raddr
    );
    modport slave (
        input  s_valid, s_data, m_ready, ram_rdata,
        output s_ready, m_valid, m_data, ram_wr_en, ram_waddr, ram_wdata, ram_raddr
    );
endinterface

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// fifo_ptr: wrap-extended FIFO pointer with increment enable, exposing current and next values
module fifo_ptr #(parameter int PW = 5) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o,
    output logic [PW-1:0] nxt_o
);
    logic [PW-1:0] ptr_q, ptr_d;
    assign ptr_d = ptr_q + PW'(inc_i);
    assign ptr_o = ptr_q;
    assign nxt_o = ptr_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller over an external RAM with registered read data.
// Define RAM_FIFO_STATUS_EN to add count/almost_full/almost_empty outputs.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_fifo_ctrl_if.slave        bus,
    output logic                  full,
    output logic                  empty
`ifdef RAM_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   almost_empty
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt, wr_nxt_unused, wr_vis_q;
    rd_state_e     state_q, state_d;
    logic          push, pop;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty = wr_ptr == rd_ptr;
    // reset gates the write strobe so the RAM is never written while held in reset
    assign push  = bus.s_valid && !full && rst_n;
    assign pop   = bus.m_valid && bus.m_ready;
    fifo_ptr #(.PW(PW)) u_wr (.clk(clk), .rst_n(rst_n), .inc_i(push), .ptr_o(wr_ptr), .nxt_o(wr_nxt_unused));
    fifo_ptr #(.PW(PW)) u_rd (.clk(clk), .rst_n(rst_n), .inc_i(pop), .ptr_o(rd_ptr), .nxt_o(rd_nxt));
    assign bus.s_ready   = !full;
    assign bus.ram_wr_en = push;
    assign bus.ram_waddr = wr_ptr[AW-1:0];
    assign bus.ram_wdata = bus.s_data;
    assign bus.ram_raddr = rd_nxt[AW-1:0];
    assign bus.m_data    = bus.ram_rdata;
    assign bus.m_valid   = state_q == ACTIVE;
    // wr_vis lags wr_ptr so a word is only read after its RAM write has landed
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? ((rd_nxt != wr_vis_q) ? ACTIVE : IDLE)
                                    : ((pop && rd_nxt == wr_vis_q) ? IDLE : ACTIVE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vis_q <= '0;
            state_q  <= IDLE;
        end else begin
            wr_vis_q <= wr_ptr;
            state_q  <= state_d;
        end
    end
`ifdef RAM_FIFO_STATUS_EN
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = count >= PW'(DEPTH - ALMOST_THR);
    assign almost_empty = count <= PW'(ALMOST_THR);
`endif
endmodule
